regfile_param_2w2r: RTL

//  Parametrised 2-write / 2-read register file, successor of the fixed 4x16 block.

---
 rtl/regfile_param_2w2r.sv | 90 +++++++++
 1 files changed

// File: rtl/regfile_param_2w2r.sv
// Two-write / two-read register file with registered reads, optional same-cycle
// write-to-read forwarding, optional hardwired-zero entry 0 and a write-collision flag.
module regfile_param_2w2r #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] WA1,
    input  logic [DATA_W-1:0] WD1,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] WA2,
    input  logic [DATA_W-1:0] WD2,
    input  logic              WE2,
    input  logic [ADDR_W-1:0] RAA,
    input  logic              REA,
    output logic [DATA_W-1:0] RDA,
    output logic              RVA,
    input  logic [ADDR_W-1:0] RAB,
    input  logic              REB,
    output logic [DATA_W-1:0] RDB,
    output logic              RVB,
    output logic              COLL
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [ADDR_W-1:0] rd_addr [2];
    logic              rd_en   [2];
    logic [DATA_W-1:0] rd_val_d  [2];
    logic [DATA_W-1:0] rd_data_q [2];
    logic              rd_vld_q  [2];
    logic              coll_q;
    logic              coll_d;
    logic              wr1_ok;
    logic              wr2_ok;

    assign rd_addr[0] = RAA;
    assign rd_addr[1] = RAB;
    assign rd_en[0]   = REA;
    assign rd_en[1]   = REB;

    // Writes aimed at a hardwired-zero entry 0 are suppressed.
    assign wr1_ok = WE1 && !((ZERO_REG != 0) && (WA1 == '0));
    assign wr2_ok = WE2 && !((ZERO_REG != 0) && (WA2 == '0));
    assign coll_d = WE1 && WE2 && (WA1 == WA2);

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val_d[p] = mem[rd_addr[p]];
            // Port 2 is checked last so it wins a same-address forwarding tie.
            if ((BYPASS != 0) && WE1 && (WA1 == rd_addr[p])) rd_val_d[p] = WD1;
            if ((BYPASS != 0) && WE2 && (WA2 == rd_addr[p])) rd_val_d[p] = WD2;
            if ((ZERO_REG != 0) && (rd_addr[p] == '0))       rd_val_d[p] = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr1_ok) mem[WA1] <= WD1;
            if (wr2_ok) mem[WA2] <= WD2;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int p = 0; p < 2; p++) begin
                rd_data_q[p] <= '0;
                rd_vld_q[p]  <= 1'b0;
            end
            coll_q <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                rd_vld_q[p] <= rd_en[p];
                if (rd_en[p]) rd_data_q[p] <= rd_val_d[p];
            end
            coll_q <= coll_d;
        end
    end

    assign RDA  = rd_data_q[0];
    assign RVA  = rd_vld_q[0];
    assign RDB  = rd_data_q[1];
    assign RVB  = rd_vld_q[1];
    assign COLL = coll_q;
endmodule
